// File: rtl/ls_datapath_param.sv
// ls_datapath_param
//   Load/store datapath with a register file and an internal data RAM. It
//   executes one command at a time through IDLE -> ADDR -> MEM -> WB.
//   Effective address / ADDI result = imm + reg[base]. The carry is dropped.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               command request, taken only while ready=1
//   op                  00 LOAD, 01 STORE, 10 ADDI, 11 reserved (error)
//   imm, base, src, rd  command operands
//   ready               high only in IDLE
//   done, err           one-cycle completion pulse; err is coincident with done
//   a, b / douta, doutb combinational debug reads of the register file
module ls_datapath_param #(
  parameter  int WIDTH = 64,
  parameter  int NREGS = 32,
  parameter  int DEPTH = 32,
  localparam int RW    = $clog2(NREGS),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] imm,
  input  logic [RW-1:0]    base,
  input  logic [RW-1:0]    src,
  input  logic [RW-1:0]    rd,
  output logic             ready,
  output logic             done,
  output logic             err,
  input  logic [RW-1:0]    a,
  input  logic [RW-1:0]    b,
  output logic [WIDTH-1:0] douta,
  output logic [WIDTH-1:0] doutb
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADDI  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_MEM, S_WB} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] imm;
    logic [RW-1:0]    base;
    logic [RW-1:0]    src;
    logic [RW-1:0]    rd;
  } cmd_t;

  state_t                     state_q;
  cmd_t                       cmd_q;
  logic                       ready_q, done_q, err_q;
  logic [WIDTH-1:0]           sum_q;
  logic                       fault_q;
  logic [WIDTH-1:0]           rdata_q;
  logic [NREGS-1:0][WIDTH-1:0] rf_q;
  logic [WIDTH-1:0]           mem_q [DEPTH];

  logic [WIDTH-1:0] sum_d;
  logic             is_mem_op;
  logic             fault_d;

  // The address adder works at full width, so out-of-range sums are detected
  // before the RAM index is truncated to AW bits.
  always_comb begin
    sum_d     = cmd_q.imm + rf_q[cmd_q.base];
    is_mem_op = (cmd_q.op == OP_LOAD) || (cmd_q.op == OP_STORE);
    fault_d   = (cmd_q.op == OP_RSVD) ||
                (is_mem_op && (sum_d >= WIDTH'(DEPTH)));
  end

  // Control FSM and register file. rf_q[0] is reset to zero and is never
  // written, so it always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cmd_q   <= '0;
      sum_q   <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= WIDTH'(i);
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (start) begin
            cmd_q   <= '{op: op, imm: imm, base: base, src: src, rd: rd};
            ready_q <= 1'b0;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          sum_q   <= sum_d;
          fault_q <= fault_d;
          state_q <= S_MEM;
        end
        S_MEM: begin
          // Raise done/err now so that both are high while in WB.
          done_q  <= 1'b1;
          err_q   <= fault_q;
          state_q <= S_WB;
        end
        S_WB: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
          if (!fault_q && (cmd_q.rd != '0)) begin
            if (cmd_q.op == OP_LOAD) rf_q[cmd_q.rd] <= rdata_q;
            if (cmd_q.op == OP_ADDI) rf_q[cmd_q.rd] <= sum_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The data RAM is not reset. Each access is qualified by state_q == S_MEM.
  // A reset forces the FSM to IDLE at once, so a command aborted by reset
  // does not write the RAM on a later edge.
  always_ff @(posedge clk) begin
    if (state_q == S_MEM && !fault_q) begin
      if (cmd_q.op == OP_STORE) mem_q[sum_q[AW-1:0]] <= rf_q[cmd_q.src];
      if (cmd_q.op == OP_LOAD)  rdata_q <= mem_q[sum_q[AW-1:0]];
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign err   = err_q;
  assign douta = rf_q[a];
  assign doutb = rf_q[b];

endmodule

// File: tb/tb_ls_datapath_param.sv
module tb_ls_datapath_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [63:0] imm = '0;
  logic [4:0]  base = '0, src = '0, rd = '0, a = '0, b = '0;
  logic        ready, done, err;
  logic [63:0] douta, doutb;

  int n_cmp = 0;
  int n_bad = 0;

  ls_datapath_param #(.WIDTH(64), .NREGS(32), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .imm(imm),
    .base(base), .src(src), .rd(rd), .ready(ready), .done(done), .err(err),
    .a(a), .b(b), .douta(douta), .doutb(doutb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_reg(input string tag, input logic [4:0] idx, input logic [63:0] exp);
    a = idx;
    #1;
    chk(tag, douta, exp);
  endtask

  // Issue one command from IDLE, check that done arrives on the 3rd cycle,
  // check err, and check that ready is back one cycle later.
  task automatic run_cmd(input string tag, input logic [1:0] o, input logic [63:0] im,
                         input logic [4:0] bs, input logic [4:0] sr, input logic [4:0] r,
                         input logic exp_err);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; imm = im; base = bs; src = sr; rd = r;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'd3);
    chk({tag, ".err"}, {63'd0, err}, {63'd0, exp_err});
    @(negedge clk);
    chk({tag, ".rdy"}, {63'd0, ready}, 64'd1);
  endtask

  initial begin : main
    int npulse;
    // 1. reset
    #12;
    a = 5'd2; b = 5'd31;
    #1;
    chk("rst.douta", douta, 64'd2);
    chk("rst.doutb", doutb, 64'd31);
    chk("rst.ready", {63'd0, ready}, 64'd1);
    chk("rst.done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. stores then loads
    run_cmd("st0", 2'b01, 64'd0, 5'd0, 5'd2, 5'd0, 1'b0);   // mem[0]=2
    run_cmd("st8", 2'b01, 64'd2, 5'd6, 5'd4, 5'd0, 1'b0);   // mem[8]=4
    run_cmd("ld30", 2'b00, 64'd0, 5'd0, 5'd0, 5'd30, 1'b0);
    run_cmd("ld31", 2'b00, 64'd8, 5'd0, 5'd0, 5'd31, 1'b0);
    rd_reg("r30", 5'd30, 64'd2);
    rd_reg("r31", 5'd31, 64'd4);

    // 3. range fault, then a sum that wraps to 0
    run_cmd("ldrange", 2'b00, 64'd40, 5'd0, 5'd0, 5'd5, 1'b1);
    rd_reg("r5keep", 5'd5, 64'd5);
    run_cmd("ldwrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 5'd0, 5'd5, 1'b0);
    rd_reg("r5wrap", 5'd5, 64'd2);

    // 4. ADDI, protected reg0, reserved op
    run_cmd("addi0", 2'b10, 64'd7, 5'd3, 5'd0, 5'd0, 1'b0);
    rd_reg("r0", 5'd0, 64'd0);
    run_cmd("addi7", 2'b10, 64'd7, 5'd3, 5'd0, 5'd7, 1'b0);
    rd_reg("r7", 5'd7, 64'd10);
    run_cmd("rsvd", 2'b11, 64'd0, 5'd0, 5'd0, 5'd7, 1'b1);
    rd_reg("r7keep", 5'd7, 64'd10);

    // 5. start held through ADDR/MEM/WB with a different command is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b10; imm = 64'd1; base = 5'd3; rd = 5'd8;
    @(negedge clk);                       // ADDR
    chk("busy.addr", {63'd0, done}, 64'd0);
    imm = 64'd100; rd = 5'd9;
    @(negedge clk);                       // MEM
    chk("busy.mem", {63'd0, done}, 64'd0);
    @(negedge clk);                       // WB
    chk("busy.wb", {63'd0, done}, 64'd1);
    @(negedge clk);                       // IDLE
    start = 1'b0;
    chk("busy.rdy", {63'd0, ready}, 64'd1);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
    end
    chk("busy.extra", 64'(npulse), 64'd0);
    rd_reg("r8", 5'd8, 64'd4);
    rd_reg("r9", 5'd9, 64'd9);

    // 6. reset during MEM of a LOAD
    @(negedge clk);
    start = 1'b1; op = 2'b00; imm = 64'd0; base = 5'd0; rd = 5'd9;
    @(negedge clk);                       // ADDR
    start = 1'b0;
    @(negedge clk);                       // MEM
    rst_n = 1'b0;
    #1;
    chk("abort.rdy", {63'd0, ready}, 64'd1);
    chk("abort.done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
    end
    chk("abort.pulse", 64'(npulse), 64'd0);
    rd_reg("r9abort", 5'd9, 64'd9);
    rd_reg("r30rst", 5'd30, 64'd30);
    // the RAM is not reset, so mem[8] still holds 4
    run_cmd("ldpersist", 2'b00, 64'd8, 5'd0, 5'd0, 5'd10, 1'b0);
    rd_reg("r10", 5'd10, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end
endmodule
